// File: rtl/joystick_array_if.sv
// Joystick bus: raw button lines in, debounced level/event/LED vectors out.
// Line index is p*NUM_BTNS+b.
interface joystick_array_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BTNS    = 5
);
    localparam int N = NUM_PLAYERS * NUM_BTNS;

    logic [N-1:0] i_btn_raw;
    logic [N-1:0] o_level;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;
    logic         o_any_press;
    logic [N-1:0] o_led;

    modport master (
        output i_btn_raw,
        input  o_level, o_press, o_release, o_any_press, o_led
    );

    modport slave (
        input  i_btn_raw,
        output o_level, o_press, o_release, o_any_press, o_led
    );
endinterface

// File: rtl/joystick_array.sv
// Multi-player joystick front end: per-line sync, debounce, press/release events.
// Optional auto-repeat is built only when JOY_AUTOREPEAT_EN is defined.
module joystick_lane #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter bit REP_EN          = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_d
);
    localparam int             DW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  D_TERM = DW'(DEBOUNCE_CYCLES - 1);

    logic          nrm;
    logic [1:0]    sync;
    logic          stable;
    logic [DW-1:0] cnt;
    logic          differ, toggle, rise, fall, rep_fire;

    assign nrm    = (ACTIVE_LOW != 0) ? ~raw : raw;
    assign differ = sync[1] ^ stable;
    assign toggle = differ && (cnt == D_TERM);
    assign rise   = toggle & ~stable;
    assign fall   = toggle & stable;

    // Counter clears on toggle, so it never passes D_TERM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            sync  <= {sync[0], nrm};
            press <= press_d;
            rel   <= fall;
            if (toggle) begin
                stable <= ~stable;
                cnt    <= '0;
            end else if (differ) begin
                cnt <= cnt + DW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level   = stable;
    assign press_d = rise | rep_fire;

`ifdef JOY_AUTOREPEAT_EN
    if (REP_EN) begin : g_rep
        typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rstate_t;
        localparam int            RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int            RW      = $clog2(RMAX + 1);
        localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] RR_TERM = RW'(REPEAT_RATE - 1);

        rstate_t       st, st_nxt;
        logic [RW-1:0] rcnt, rcnt_nxt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st   <= R_IDLE;
                rcnt <= '0;
            end else begin
                st   <= st_nxt;
                rcnt <= rcnt_nxt;
            end
        end

        always_comb begin
            st_nxt   = st;
            rcnt_nxt = rcnt;
            case (st)
                R_IDLE: if (rise) begin
                    st_nxt   = R_DELAY;
                    rcnt_nxt = '0;
                end
                R_DELAY: if (rcnt == RD_TERM) begin
                    st_nxt   = R_REPEAT;
                    rcnt_nxt = '0;
                end else begin
                    rcnt_nxt = rcnt + RW'(1);
                end
                R_REPEAT: rcnt_nxt = (rcnt == RR_TERM) ? '0 : rcnt + RW'(1);
                default: begin
                    st_nxt   = R_IDLE;
                    rcnt_nxt = '0;
                end
            endcase
            // Release wins over any pending repeat.
            if (fall) begin
                st_nxt   = R_IDLE;
                rcnt_nxt = '0;
            end
        end

        always_comb begin
            rep_fire = 1'b0;
            if (!fall) begin
                case (st)
                    R_DELAY:  rep_fire = (rcnt == RD_TERM);
                    R_REPEAT: rep_fire = (rcnt == RR_TERM);
                    default:  rep_fire = 1'b0;
                endcase
            end
        end
    end else begin : g_norep
        assign rep_fire = 1'b0;
    end
`else
    assign rep_fire = 1'b0;
`endif
endmodule

module joystick_array #(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_BTNS        = 5,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK = NUM_BTNS'(5'b01111)
) (
    input  logic             clk,
    input  logic             rst_n,
    joystick_array_if.slave  bus
);
    localparam int N = NUM_PLAYERS * NUM_BTNS;

    logic [N-1:0] level, press, rel, press_d;
    logic         any_press;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
            joystick_lane #(
                .ACTIVE_LOW      (ACTIVE_LOW),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
                .REP_EN          (REPEAT_MASK[b])
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .raw     (bus.i_btn_raw[p*NUM_BTNS+b]),
                .level   (level[p*NUM_BTNS+b]),
                .press   (press[p*NUM_BTNS+b]),
                .rel     (rel[p*NUM_BTNS+b]),
                .press_d (press_d[p*NUM_BTNS+b])
            );
        end
    end

    // Registered from the lanes' next-press terms so it lines up with o_press.
    always_ff @(posedge clk) begin
        if (!rst_n) any_press <= 1'b0;
        else        any_press <= |press_d;
    end

    assign bus.o_level     = level;
    assign bus.o_led       = level;
    assign bus.o_press     = press;
    assign bus.o_release   = rel;
    assign bus.o_any_press = any_press;
endmodule

// File: tb/tb_joystick_array.sv
// Scoreboard bench for joystick_array: directed scenarios plus random button traffic.
module tb_joystick_array;
    localparam int NP  = 2;
    localparam int NB  = 5;
    localparam int N   = NP * NB;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;
    localparam logic [NB-1:0] MASK = 5'b01111;
`ifdef JOY_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic         any;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    joystick_array_if #(.NUM_PLAYERS(NP), .NUM_BTNS(NB)) bus ();

    joystick_array #(
        .NUM_PLAYERS(NP), .NUM_BTNS(NB), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference: a line is accepted once the synchronised value has disagreed with
    // the accepted level for DEB consecutive edges; repeats follow from press age.
    bit m_s1[N], m_s2[N], m_lvl[N];
    int m_run[N], m_age[N];

    always @(posedge clk) begin
        exp_t e;
        bit   tog;
        e.level = '0; e.press = '0; e.rel = '0; e.any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_age[i] = 0;
            end else begin
                tog = 0;
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        tog = 1;
                        m_run[i] = 0;
                        m_lvl[i] = !m_lvl[i];
                        if (m_lvl[i]) begin
                            e.press[i] = 1'b1;
                            m_age[i] = 0;
                        end else begin
                            e.rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (!tog && m_lvl[i] && REP_ON && MASK[i % NB]) begin
                    m_age[i]++;
                    if (m_age[i] >= RD && (m_age[i] - RD) % RR == 0) e.press[i] = 1'b1;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = !bus.i_btn_raw[i];
                e.level[i] = m_lvl[i];
            end
        end
        e.any = |e.press;
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (bus.o_level !== e.level || bus.o_led !== e.level || bus.o_press !== e.press ||
                bus.o_release !== e.rel || bus.o_any_press !== e.any) begin
                failures++;
                $display("FAIL sb_out t=%0t level=%h/%h led=%h press=%h/%h rel=%h/%h any=%b/%b (got/exp)",
                         $time, bus.o_level, e.level, bus.o_led, bus.o_press, e.press,
                         bus.o_release, e.rel, bus.o_any_press, e.any);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int i, input bit pressed);
        bus.i_btn_raw[i] = !pressed;
    endtask

    int hold_t[N];

    initial begin
        bus.i_btn_raw = '1;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Clean press/release on P0 up.
        set_line(0, 1); cyc(20); set_line(0, 0); cyc(12);

        // Glitches on fire shorter than the debounce window.
        repeat (5) begin
            set_line(4, 1); cyc(3); set_line(4, 0); cyc(3);
        end
        cyc(10);

        // Long holds: left repeats, fire does not.
        set_line(2, 1); cyc(40); set_line(2, 0); cyc(12);
        set_line(4, 1); cyc(40); set_line(4, 0); cyc(12);

        // Same button on both players in the same cycle.
        set_line(3, 1); set_line(8, 1); cyc(10);
        set_line(3, 0); set_line(8, 0); cyc(12);

        // Reset while P0 down is auto-repeating, button still held.
        set_line(1, 1); cyc(25);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        cyc(25); set_line(1, 0); cyc(12);

        // Random traffic: mixes bounces, clean holds and occasional resets.
        for (int i = 0; i < N; i++) hold_t[i] = $urandom_range(1, 20);
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold_t[i] == 0) begin
                    bus.i_btn_raw[i] = ~bus.i_btn_raw[i];
                    hold_t[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
                end else begin
                    hold_t[i]--;
                end
            end
            rst_n = ($urandom_range(0, 399) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        bus.i_btn_raw = '1;
        cyc(15);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain left=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/joystick_array.md
# joystick_array

Parametrised multi-player joystick front end for the DE2-115 game design. It replaces the single fixed five-button player controller. It takes raw GPIO button lines for `NUM_PLAYERS` players and synchronises and debounces every line. It produces debounced levels, one-cycle press/release events and optional auto-repeat press events for the game-state logic, plus a per-button LED mirror.

## Interface
- `NUM_PLAYERS`, default 2: number of joysticks.
- `NUM_BTNS`, default 5: buttons per player. Bit order is 0 up, 1 down, 2 left, 3 right, 4 fire, then extras.
- `ACTIVE_LOW`, default 1: 1 means a raw line reads 0 when pressed.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a change (10 ms at 50 MHz). Must be ≥ 1.
- `REPEAT_DELAY`, default 25000000: cycles from accepted press to first repeat event.
- `REPEAT_RATE`, default 5000000: cycles between subsequent repeat events.
- `REPEAT_MASK`, default `NUM_BTNS'b01111`: per-button auto-repeat enable, shared by all players.
- `clk` input, 1 bit: system clock (CLOCK_50 domain).
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `i_btn_raw` input, `NUM_PLAYERS*NUM_BTNS` bits: raw asynchronous button lines. Index is `p*NUM_BTNS+b`.
- `o_level` output, `NUM_PLAYERS*NUM_BTNS` bits: debounced state, 1 = pressed.
- `o_press` output, `NUM_PLAYERS*NUM_BTNS` bits: one-cycle pulse on accepted press or repeat.
- `o_release` output, `NUM_PLAYERS*NUM_BTNS` bits: one-cycle pulse on accepted release.
- `o_any_press` output, 1 bit: OR of `o_press`, same cycle.
- `o_led` output, `NUM_PLAYERS*NUM_BTNS` bits: equal to `o_level`, for LEDG/LEDR.

## Operation
- **Normalise.** Each raw line is inverted when `ACTIVE_LOW=1`, so that 1 means pressed.
- **Synchronise.** Each line passes through a 2-flop synchroniser. Both flops reset to "released".
- **Debounce.** Each line has an independent counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - When the synced value equals the stable value, the counter clears to 0.
  - When it differs, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, the stable value toggles and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and is never accepted.
- **Edge events.**
  - A stable 0→1 toggle registers `o_press`=1 for exactly one cycle.
  - A stable 1→0 toggle registers `o_release`=1 for exactly one cycle.
- **Auto-repeat.** Applies only to buttons with their `REPEAT_MASK` bit set and only when `JOY_AUTOREPEAT_EN` is defined. Each such button runs this state machine:
  - **IDLE**: on accepted press, move to **DELAY** with the counter at 0.
  - **DELAY**: count to `REPEAT_DELAY-1`, then pulse `o_press` and move to **REPEAT** with the counter at 0.
  - **REPEAT**: count to `REPEAT_RATE-1`, pulse `o_press`, clear the counter and stay in **REPEAT**.
  - From any state, an accepted release returns the button to **IDLE**. No repeat pulse is emitted in the release cycle.
- **Independence.** All buttons and players are fully independent. Simultaneous presses on several lines produce pulses in the same cycle. Opposite directions may both be active.
- **Reset.** A reset asserted at any time, including mid-debounce or mid-repeat, clears everything to 0 or released at the next `clk` edge:
  - synchronisers, stable values, counters and repeat FSMs;
  - all outputs.
- **After reset.** A button held through reset release is accepted as a fresh press after the normal latency. No spurious release is emitted.

## Timing
- **Reset values.** `o_level`, `o_press`, `o_release`, `o_any_press` and `o_led` are all 0.
- **Latency.** A raw change held steady appears on `o_level`/`o_press`/`o_release` exactly `2 + DEBOUNCE_CYCLES` clock edges after the first sampling edge that sees it.
- **Registered outputs.** All outputs are registered. `o_press` and `o_level` rise on the same edge; `o_release` and the `o_level` fall also coincide.
- **Repeat timing.**
  - First repeat pulse: `REPEAT_DELAY` cycles after the accepted-press pulse.
  - Subsequent repeat pulses: every `REPEAT_RATE` cycles.
- **Pulse width.** A pulse is never wider than one cycle. Back-to-back pulses on one line require `REPEAT_RATE` ≥ 2.
- **Counter saturation.** Counters never exceed their terminal value, and there is no wrap-around within a state.

## Configuration
- **`JOY_AUTOREPEAT_EN` defined:** the repeat FSMs and counters are built, and `REPEAT_DELAY`, `REPEAT_RATE` and `REPEAT_MASK` take effect.
- **`JOY_AUTOREPEAT_EN` undefined:** no repeat logic is synthesised. `o_press` pulses only on debounced press edges, and the repeat parameters are ignored.

## Test plan
All scenarios use `NUM_PLAYERS=2`, `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_RATE=3` and `ACTIVE_LOW=1`.

1. **Clean press/release.** Drive P0 up (bit 0) low for 20 cycles, then high.
   - `o_level[0]` rises 6 edges after the first low sample, with a single `o_press[0]` pulse.
   - `o_release[0]` pulses 6 edges after the line returns high.
2. **Glitch rejection.** Drive bit 4 low for 3 cycles, then high, repeated 5 times.
   - `o_level`, `o_press` and `o_release` stay 0 throughout.
3. **Auto-repeat, built with `JOY_AUTOREPEAT_EN`.** Hold bit 2 for 40 cycles.
   - Press pulse at T, then repeat pulses at T+10, T+13, T+16, and so on.
   - Hold bit 4 (fire, mask 0) for 40 cycles: exactly one press pulse.
4. **Simultaneous players.** Press P0 bit 3 and P1 bit 3 (index 8) on the same cycle.
   - `o_press[3]` and `o_press[8]` pulse on the same edge, with `o_any_press`=1 for one cycle.
5. **Reset mid-repeat.** Assert `rst_n`=0 for 1 cycle during the REPEAT state while the button is held.
   - All outputs are 0 on the next edge.
   - A fresh `o_press` arrives 6 edges after reset release, with no `o_release`.
6. **Macro off.** Rebuild without `JOY_AUTOREPEAT_EN` and repeat scenario 3.
   - Only the single press pulse at T appears.
